// File: rtl/arb_pkg.sv
// Shared types and defaults for the round-robin arbiter slice.
// State encoding and requester-count defaults used by rr_arbiter8 and prio_enc8.
package arb_pkg;

    localparam int N_REQ  = 8;
    localparam int IW_REQ = $clog2(N_REQ);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/prio_enc8.sv
// Lowest-set-bit priority encoder: N-bit vector in, IW-bit index out,
// plus a flag that is high when any input bit is set.
module prio_enc8
    import arb_pkg::*;
#(
    parameter int N  = N_REQ,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          any
);

    // Scanning from the top down lets the lowest set bit overwrite last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter: rotating-priority one-hot grant held while the owner requests.
// Optional macro ARB_TIMEOUT_EN forcibly revokes a grant after MAX_HOLD cycles.
module rr_arbiter8
    import arb_pkg::*;
#(
    parameter int N        = N_REQ,
    parameter int IW       = $clog2(N),
    parameter int MAX_HOLD = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_valid,
    output logic          timeout
);

    if (N < 2 || MAX_HOLD < 1) begin : g_bad_params
        $error("rr_arbiter8: N must be >= 2 and MAX_HOLD >= 1");
    end

    arb_state_t    state, state_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [N-1:0]  gnt_n;
    logic [IW-1:0] gnt_idx_n;

    logic [2*N-1:0] req_dbl;
    logic [N-1:0]   req_rot;
    logic [IW-1:0]  enc_idx;
    logic           enc_any;
    logic [IW:0]    idx_sum;
    logic [IW-1:0]  winner;
    logic [IW-1:0]  winner_inc;

    // Rotate requests so bit 0 of req_rot is requester ptr; the encoder's
    // fixed lowest-bit priority then becomes priority relative to ptr.
    always_comb begin
        req_dbl = {req, req} >> ptr;
        req_rot = req_dbl[N-1:0];
    end

    prio_enc8 #(
        .N  (N),
        .IW (IW)
    ) u_prio_enc (
        .vec (req_rot),
        .idx (enc_idx),
        .any (enc_any)
    );

    always_comb begin
        idx_sum = {1'b0, enc_idx} + {1'b0, ptr};
        if (idx_sum >= (IW+1)'(N)) begin
            winner = IW'(idx_sum - (IW+1)'(N));
        end else begin
            winner = idx_sum[IW-1:0];
        end
        if (winner == IW'(N - 1)) begin
            winner_inc = '0;
        end else begin
            winner_inc = winner + 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;

    logic [HW-1:0] hold_cnt, hold_cnt_n;
    logic          timeout_q, timeout_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_n;
            timeout_q <= timeout_n;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            gnt     <= '0;
            gnt_idx <= '0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            gnt     <= gnt_n;
            gnt_idx <= gnt_idx_n;
        end
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        gnt_n     = gnt;
        gnt_idx_n = gnt_idx;
`ifdef ARB_TIMEOUT_EN
        hold_cnt_n = hold_cnt;
        timeout_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (enc_any) begin
                    state_n   = GRANT;
                    gnt_n     = {{(N-1){1'b0}}, 1'b1} << winner;
                    gnt_idx_n = winner;
                    ptr_n     = winner_inc;
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_n = '0;
`endif
                end else begin
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                end
            end
            GRANT: begin
                if (!req[gnt_idx]) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                end
`ifdef ARB_TIMEOUT_EN
                // ptr already points past the owner, so a revoked owner
                // goes to the back of the rotation.
                else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                    state_n   = IDLE;
                    gnt_n     = '0;
                    gnt_idx_n = '0;
                    timeout_n = 1'b1;
                end else begin
                    hold_cnt_n = hold_cnt + 1'b1;
                end
`endif
            end
            default: begin
                state_n   = IDLE;
                gnt_n     = '0;
                gnt_idx_n = '0;
            end
        endcase
    end

    assign gnt_valid = |gnt;

endmodule
